param_dcache: RTL and testbench

PARAM_DCACHE -- requirements
Module: param_dcache

---
 rtl/param_dcache_if.sv | 34 +++
 rtl/param_dcache.sv | 151 +++++++++++++++
 tb/tb_param_dcache.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_dcache_if.sv
// CPU-side and memory-side signals of the direct-mapped write-through data cache.
// The cache is the slave; the CPU/memory environment is the master.
interface param_dcache_if #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 8
);
    logic                    req_valid;
    logic                    req_we;
    logic                    req_word;
    logic [ADDR_W-1:0]       req_addr;
    logic [31:0]             req_wdata;
    logic [31:0]             rdata;
    logic                    stall;
    logic                    flush;
    logic                    mem_req;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [31:0]             mem_wdata;
    logic                    mem_word;
    logic                    mem_ack;
    logic [8*LINE_BYTES-1:0] mem_rdata;
    logic [31:0]             hit_cnt;
    logic [31:0]             miss_cnt;

    modport master (
        output req_valid, req_we, req_word, req_addr, req_wdata, flush, mem_ack, mem_rdata,
        input  rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_word, hit_cnt, miss_cnt
    );

    modport slave (
        input  req_valid, req_we, req_word, req_addr, req_wdata, flush, mem_ack, mem_rdata,
        output rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_word, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/param_dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with line refill,
// combinational load-hit data and saturating load hit/miss counters.
module param_dcache #(
    parameter int LINES      = 32,
    parameter int LINE_BYTES = 8,
    parameter int ADDR_W     = 32
) (
    input  logic          clk,
    input  logic          rst,
    param_dcache_if.slave bus
);
    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

    state_t             state_q, state_d;
    logic [7:0]         data_q [LINES][LINE_BYTES];
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [LINES-1:0]   valid_q;
    logic [31:0]        hit_cnt_q, miss_cnt_q;
    logic               refill_done_q;

    logic [OFF_W-1:0]   off, woff;
    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic               stall, mem_req, mem_we, hit_inc, miss_inc;
    logic               refill_we, store_we;
    logic [7:0]         word_bytes [4];
    logic [7:0]         sel_byte;

    assign off  = bus.req_addr[OFF_W-1:0];
    assign woff = off & ~OFF_W'(3);
    assign idx  = bus.req_addr[OFF_W +: IDX_W];
    assign tag  = bus.req_addr[ADDR_W-1 -: TAG_W];
    assign hit  = valid_q[idx] && (tag_q[idx] == tag);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_word_rd
            assign word_bytes[gi] = data_q[idx][woff | OFF_W'(gi)];
        end
    endgenerate

    assign sel_byte  = data_q[idx][off];
    assign bus.rdata = bus.req_word ? {word_bytes[3], word_bytes[2], word_bytes[1], word_bytes[0]}
                                    : {{24{sel_byte[7]}}, sel_byte};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are forced quiet while reset is held, even with a request pending.
    always_comb begin
        state_d  = state_q;
        stall    = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        hit_inc  = 1'b0;
        miss_inc = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (bus.req_we) begin
                            stall   = 1'b1;
                            state_d = WRITE;
                        end else if (hit) begin
                            hit_inc = !refill_done_q;
                        end else begin
                            stall    = 1'b1;
                            miss_inc = 1'b1;
                            state_d  = REFILL;
                        end
                    end
                end
                REFILL: begin
                    mem_req = 1'b1;
                    stall   = 1'b1;
                    if (bus.mem_ack) state_d = IDLE;
                end
                WRITE: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    stall   = !bus.mem_ack;
                    if (bus.mem_ack) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign refill_we = !rst && (state_q == REFILL) && bus.mem_ack;
    assign store_we  = !rst && (state_q == WRITE) && bus.mem_ack && hit;

    assign bus.stall     = stall;
    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = (state_q == WRITE) ? bus.req_addr
                                              : {bus.req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
    assign bus.mem_wdata = bus.req_wdata;
    assign bus.mem_word  = bus.req_word;
    assign bus.hit_cnt   = hit_cnt_q;
    assign bus.miss_cnt  = miss_cnt_q;

    // Data and tags carry no reset; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (refill_we) begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                data_q[idx][OFF_W'(b)] <= bus.mem_rdata[8*b +: 8];
            end
            tag_q[idx] <= tag;
        end else if (store_we) begin
            if (bus.req_word) begin
                for (int k = 0; k < 4; k++) begin
                    data_q[idx][woff | OFF_W'(k)] <= bus.req_wdata[8*k +: 8];
                end
            end else begin
                data_q[idx][off] <= bus.req_wdata[7:0];
            end
        end
    end

    // A flush wins over a coinciding refill: the line is written but left invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (bus.flush) begin
            valid_q <= '0;
        end else if (refill_we) begin
            valid_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
            refill_done_q <= 1'b0;
        end else begin
            refill_done_q <= refill_we;
            if (hit_inc && (hit_cnt_q != 32'hFFFF_FFFF)) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (miss_inc && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end
endmodule

// File: tb/tb_param_dcache.sv
// Randomized bench for param_dcache: a byte-array memory plus a line-residency model
// predicts load data, hit/miss outcome and counters for every CPU access.
module tb_param_dcache;
    localparam int LINES      = 32;
    localparam int LINE_BYTES = 8;
    localparam int ADDR_W     = 32;
    localparam int MEM_BYTES  = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    param_dcache_if #(.ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES)) bus ();

    param_dcache #(.LINES(LINES), .LINE_BYTES(LINE_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [7:0] mem_img [MEM_BYTES];
    logic [7:0] ref_mem [MEM_BYTES];
    int         resident [LINES];
    int         hit_exp, miss_exp;
    int         vectors, miscompares;
    bit         resp_en;
    int         manual_req, manual_done;
    int         wait_cnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input bit word, input int addr);
        int a;
        if (word) begin
            a = addr & ~3;
            return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
        end
        return {{24{ref_mem[addr][7]}}, ref_mem[addr]};
    endfunction

    task automatic model_flush();
        for (int i = 0; i < LINES; i++) resident[i] = -1;
    endtask

    // Memory responder: random 0..3 cycle latency, or an ack on demand from the main flow.
    initial begin
        int base;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        wait_cnt      = -1;
        manual_done   = 0;
        forever begin
            @(posedge clk);
            #2;
            base = int'(bus.mem_addr) % MEM_BYTES;
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
            end else if (manual_req != manual_done) begin
                for (int b = 0; b < LINE_BYTES; b++) bus.mem_rdata[8*b +: 8] = mem_img[(base + b) % MEM_BYTES];
                bus.mem_ack = 1'b1;
                manual_done++;
            end else if (resp_en && bus.mem_req && !rst) begin
                if (wait_cnt < 0) wait_cnt = $urandom_range(0, 3);
                if (wait_cnt == 0) begin
                    if (bus.mem_we) begin
                        if (bus.mem_word) begin
                            for (int k = 0; k < 4; k++) mem_img[(base & ~3) + k] = bus.mem_wdata[8*k +: 8];
                        end else begin
                            mem_img[base] = bus.mem_wdata[7:0];
                        end
                    end else begin
                        for (int b = 0; b < LINE_BYTES; b++) bus.mem_rdata[8*b +: 8] = mem_img[(base + b) % MEM_BYTES];
                    end
                    bus.mem_ack = 1'b1;
                    wait_cnt    = -1;
                end else begin
                    wait_cnt--;
                end
            end else begin
                wait_cnt = -1;
            end
        end
    end

    // One CPU access; entered and left 1 time unit after a rising edge.
    task automatic cpu_op(input bit we, input bit word, input int addr, input logic [31:0] wdata,
                          output logic [31:0] rd);
        int          idx, line, stalls;
        bit          hit, seen_mem;
        logic [31:0] exp;
        idx  = (addr >> 3) % LINES;
        line = addr >> 3;
        hit  = (resident[idx] == line);
        exp  = ref_load(word, addr);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_word  = word;
        bus.req_addr  = ADDR_W'(addr);
        bus.req_wdata = wdata;
        stalls   = 0;
        seen_mem = 0;
        rd       = '0;
        while (stalls < 100) begin
            @(negedge clk);
            if (bus.mem_req && !seen_mem) begin
                seen_mem = 1;
                if (we) begin
                    check_val("wr_addr", bus.mem_addr, 32'(addr));
                    check_val("wr_data", bus.mem_wdata, wdata);
                    check_val("wr_word", 32'(bus.mem_word), 32'(word));
                    check_val("wr_we", 32'(bus.mem_we), 32'd1);
                end else begin
                    check_val("refill_addr", bus.mem_addr, 32'(addr & ~7));
                    check_val("refill_we", 32'(bus.mem_we), 32'd0);
                end
            end
            if (!bus.stall) break;
            stalls++;
        end
        if (stalls >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: stall still high after %0d cycles, required release", stalls);
        end
        rd = bus.rdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        if (we) begin
            check_val("wr_issued", 32'(seen_mem), 32'd1);
            if (word) begin
                for (int k = 0; k < 4; k++) ref_mem[(addr & ~3) + k] = wdata[8*k +: 8];
            end else begin
                ref_mem[addr] = wdata[7:0];
            end
        end else begin
            check_val("load_data", rd, exp);
            check_val("load_hit", 32'(stalls == 0), 32'(hit));
            if (hit) hit_exp++;
            else begin
                miss_exp++;
                resident[idx] = line;
            end
        end
        check_val("hit_cnt", bus.hit_cnt, 32'(hit_exp));
        check_val("miss_cnt", bus.miss_cnt, 32'(miss_exp));
        $display("op %s %s addr=%h wdata=%h rdata=%h stalls=%0d hits=%0d misses=%0d",
                 we ? "store" : "load ", word ? "word" : "byte", addr, wdata, rd, stalls,
                 bus.hit_cnt, bus.miss_cnt);
    endtask

    task automatic flush_pulse();
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        model_flush();
        $display("op flush");
    endtask

    task automatic wait_mem_req(input string tag);
        int n;
        n = 0;
        while (!bus.mem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, 32'(bus.mem_req), 32'd1);
    endtask

    // Flush arriving in the same cycle as the refill ack: the load must miss again.
    task automatic flush_in_ack(input int addr);
        int n;
        logic [31:0] rd;
        resp_en = 0;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_word = 1'b1;
        bus.req_addr = ADDR_W'(addr); bus.req_wdata = '0;
        miss_exp++;
        wait_mem_req("fa_refill_seen");
        @(posedge clk); #1;
        manual_req++;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        model_flush();
        @(negedge clk);
        check_val("fa_restall", 32'(bus.stall), 32'd1);
        miss_exp++;
        resident[(addr >> 3) % LINES] = addr >> 3;
        resp_en = 1;
        n = 0;
        while (bus.stall && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("fa_released", 32'(bus.stall), 32'd0);
        rd = bus.rdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check_val("fa_data", rd, ref_load(1'b1, addr));
        check_val("fa_miss_cnt", bus.miss_cnt, 32'(miss_exp));
        check_val("fa_hit_cnt", bus.hit_cnt, 32'(hit_exp));
        $display("op load word addr=%h with flush on refill ack, rdata=%h misses=%0d", addr, rd, bus.miss_cnt);
    endtask

    // Reset in the middle of a refill, followed by a stray ack.
    task automatic reset_mid_refill(input int addr);
        logic [31:0] rd;
        flush_pulse();
        resp_en = 0;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_word = 1'b1;
        bus.req_addr = ADDR_W'(addr); bus.req_wdata = '0;
        wait_mem_req("rr_refill_seen");
        rst = 1'b1;
        #1;
        check_val("rr_mem_req", 32'(bus.mem_req), 32'd0);
        check_val("rr_stall", 32'(bus.stall), 32'd0);
        check_val("rr_hit_cnt", bus.hit_cnt, 32'd0);
        check_val("rr_miss_cnt", bus.miss_cnt, 32'd0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        manual_req++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("rr_after_ack_req", 32'(bus.mem_req), 32'd0);
        check_val("rr_after_ack_stall", 32'(bus.stall), 32'd0);
        hit_exp  = 0;
        miss_exp = 0;
        model_flush();
        resp_en = 1;
        $display("op reset during refill at addr=%h", addr);
        cpu_op(1'b0, 1'b1, addr, 32'd0, rd);
    endtask

    initial begin
        logic [31:0] rd;
        int          a;
        vectors = 0; miscompares = 0; hit_exp = 0; miss_exp = 0;
        manual_req = 0;
        resp_en = 1;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_word = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.flush = 1'b0;
        for (int i = 0; i < MEM_BYTES; i++) mem_img[i] = 8'(i * 37 + 11);
        for (int k = 0; k < 8; k++) mem_img[256 + k] = 8'(17 * (k + 1));
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = mem_img[i];
        model_flush();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_stall", 32'(bus.stall), 32'd0);
        check_val("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check_val("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check_val("rst_hit_cnt", bus.hit_cnt, 32'd0);
        check_val("rst_miss_cnt", bus.miss_cnt, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        cpu_op(1'b0, 1'b1, 'h100, 32'd0, rd);
        check_val("first_fill_word", rd, 32'h4433_2211);
        cpu_op(1'b0, 1'b0, 'h107, 32'd0, rd);
        check_val("byte_sign_ext", rd, 32'hFFFF_FF88);
        cpu_op(1'b1, 1'b1, 'h104, 32'hDEAD_BEEF, rd);
        cpu_op(1'b0, 1'b1, 'h104, 32'd0, rd);
        check_val("store_hit_data", rd, 32'hDEAD_BEEF);
        cpu_op(1'b1, 1'b1, 'h200, 32'h0BAD_F00D, rd);
        cpu_op(1'b0, 1'b1, 'h200, 32'd0, rd);
        check_val("store_miss_mem", rd, 32'h0BAD_F00D);
        cpu_op(1'b0, 1'b1, 'h100, 32'd0, rd);
        flush_pulse();
        cpu_op(1'b0, 1'b1, 'h100, 32'd0, rd);
        flush_in_ack('h1A8);

        resp_en = 0;
        manual_req++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("idle_ack_mem_req", 32'(bus.mem_req), 32'd0);
        resp_en = 1;
        cpu_op(1'b0, 1'b1, 'h104, 32'd0, rd);

        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 24) == 0) flush_pulse();
            a = int'(($urandom_range(0, 3) << 8) | $urandom_range(0, 255));
            cpu_op($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), a, $urandom, rd);
        end

        reset_mid_refill('h1A8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
